// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel interval timer: mode codes, the
// per-channel state encoding and the interval range helper.
package timer_pkg;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_RETRIG   = 2'b10;
   localparam logic [1:0] MODE_RESERVED = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   // Longest interval a channel can be asked for: BASE shifted by the largest multiplier.
   function automatic longint unsigned max_interval(input int unsigned base,
                                                    input int unsigned mult_w);
      return 64'(base) << ((1 << mult_w) - 1);
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One retriggerable interval timer: IDLE/COUNT FSM, up-counter, and the
// target/mode latched at trigger time.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int BASE   = 7,
   parameter int MULT_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tr_i,
   input  logic [MULT_W-1:0] mult_i,
   input  logic [1:0]        mode_i,
   input  logic              abort_i,
   output logic              cf_o,
   output logic              done_o,
   output logic [WIDTH-1:0]  count_o
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [1:0]       mode_q, mode_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] load_tgt;
   logic             expired;
   logic             retrig;

   assign load_tgt = WIDTH'(BASE) << mult_i;
   assign expired  = (cnt_q == tgt_q);
   assign retrig   = tr_i && (mode_q == MODE_RETRIG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         mode_q  <= MODE_ONESHOT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (abort_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tr_i) begin
                  state_d = ST_COUNT;
                  cnt_d   = WIDTH'(1);
                  tgt_d   = load_tgt;
                  mode_d  = mode_i;
               end
            end
            ST_COUNT: begin
               // A retrigger on the expiry edge restarts the window and swallows the done.
               if (retrig) begin
                  cnt_d = WIDTH'(1);
                  tgt_d = load_tgt;
               end else if (expired) begin
                  done_d = 1'b1;
                  if (mode_q == MODE_PERIODIC) begin
                     cnt_d = WIDTH'(1);
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign cf_o    = (state_q == ST_IDLE);
   assign done_o  = done_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/multi_channel_timer.sv
// N independent retriggerable interval timers; this level only slices the
// packed buses per channel and rejects parameter sets whose intervals overflow.
module multi_channel_timer
   import timer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16,
   parameter int BASE     = 7,
   parameter int MULT_W   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       tr,
   input  logic [CHANNELS*MULT_W-1:0] multiplier,
   input  logic [CHANNELS*2-1:0]     mode,
   input  logic [CHANNELS-1:0]       abort,
   output logic [CHANNELS-1:0]       cf,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS*WIDTH-1:0] count
);

   if (CHANNELS < 1 || BASE < 1) begin : g_param_err
      $fatal(1, "multi_channel_timer: CHANNELS and BASE must both be at least 1");
   end

   // The counter has no wrap handling, so the longest interval must be representable.
   if (max_interval(BASE, MULT_W) >= (64'd1 << WIDTH)) begin : g_width_err
      $fatal(1, "multi_channel_timer: BASE << (2**MULT_W-1) does not fit in WIDTH bits");
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      timer_channel #(
         .WIDTH  (WIDTH),
         .BASE   (BASE),
         .MULT_W (MULT_W)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .tr_i    (tr[gi]),
         .mult_i  (multiplier[gi*MULT_W +: MULT_W]),
         .mode_i  (mode[gi*2 +: 2]),
         .abort_i (abort[gi]),
         .cf_o    (cf[gi]),
         .done_o  (done[gi]),
         .count_o (count[gi*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Randomized and directed bench for multi_channel_timer against a deadline-based
// reference model (each active channel tracks its start edge and interval).
module tb_multi_channel_timer;

   localparam int CH = 4;
   localparam int W  = 16;
   localparam int B  = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [CH-1:0] tr, abort;
   logic [2*CH-1:0] multiplier, mode;
   logic [CH-1:0] cf, done;
   logic [CH*W-1:0] count;

   int tests = 0;
   int fails = 0;

   // Reference model: a channel is "active" between trigger and expiry; its
   // count is simply the number of edges since the start edge.
   bit  act [CH];
   int  st  [CH];
   int  iv  [CH];
   int  md  [CH];
   int  edge_no = 0;
   logic [CH-1:0]   exp_cf;
   logic [CH-1:0]   exp_done;
   logic [CH*W-1:0] exp_cnt;

   always #5 clk = ~clk;

   multi_channel_timer #(.CHANNELS(CH), .WIDTH(W), .BASE(B), .MULT_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .tr         (tr),
      .multiplier (multiplier),
      .mode       (mode),
      .abort      (abort),
      .cf         (cf),
      .done       (done),
      .count      (count)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_no, got, expv);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         int nv;
         nv = B << multiplier[c*2 +: 2];
         exp_done[c] = 1'b0;
         if (reset || abort[c]) begin
            act[c] = 1'b0;
         end else if (!act[c]) begin
            if (tr[c]) begin
               act[c] = 1'b1; st[c] = edge_no; iv[c] = nv; md[c] = int'(mode[c*2 +: 2]);
            end
         end else if (md[c] == 2 && tr[c]) begin
            st[c] = edge_no; iv[c] = nv;
         end else if (edge_no - st[c] == iv[c]) begin
            exp_done[c] = 1'b1;
            if (md[c] == 1) st[c] = edge_no;
            else act[c] = 1'b0;
         end
         exp_cf[c] = !act[c];
         exp_cnt[c*W +: W] = act[c] ? W'(edge_no - st[c] + 1) : '0;
      end
      edge_no++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("cf", 64'(cf), 64'(exp_cf));
      chk("done", 64'(done), 64'(exp_done));
      chk("count", 64'(count), 64'(exp_cnt));
   endtask

   task automatic idle_all();
      tr = '0; abort = '1;
      step();
      abort = '0;
   endtask

   initial begin
      int lows, dns, highs;
      int dstep [CH];
      reset = 1'b1; tr = '0; abort = '0; multiplier = '0; mode = '0;
      for (int c = 0; c < CH; c++) begin act[c] = 0; st[c] = 0; iv[c] = 0; md[c] = 0; end
      exp_cf = '1; exp_done = '0; exp_cnt = '0;
      #2;
      chk("rst_cf", 64'(cf), 64'hF);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_count", 64'(count), 64'h0);
      repeat (2) step();
      reset = 1'b0;

      // 1: one-shot, 7-cycle window, count 1..7
      mode[1:0] = 2'b00; multiplier[1:0] = 2'd0; tr[0] = 1'b1;
      lows = 0; dns = 0;
      for (int j = 1; j <= 9; j++) begin
         step();
         tr[0] = 1'b0;
         if (j <= 7) chk("t1_count", 64'(count[W-1:0]), 64'(j));
         if (j == 8) chk("t1_rise_done", 64'({cf[0], done[0]}), 64'h3);
         lows += (cf[0] == 1'b0);
         dns  += done[0];
      end
      chk("t1_lows", 64'(lows), 64'd7);
      chk("t1_dones", 64'(dns), 64'd1);

      // 2: periodic, 28-cycle period, then abort
      mode[3:2] = 2'b01; multiplier[3:2] = 2'd2; tr[1] = 1'b1;
      dns = 0; lows = 0;
      for (int j = 1; j <= 60; j++) begin
         step();
         tr[1] = 1'b0;
         dns  += done[1];
         lows += (cf[1] == 1'b0);
         if (j == 29 || j == 57) chk("t2_done_pos", 64'(done[1]), 64'h1);
      end
      chk("t2_dones", 64'(dns), 64'd2);
      chk("t2_lows", 64'(lows), 64'd60);
      abort[1] = 1'b1;
      step();
      abort[1] = 1'b0;
      chk("t2_abort", 64'({cf[1], done[1]}), 64'h2);

      // 3: retrigger at count 10 stretches the window to 24 cycles
      mode[5:4] = 2'b10; multiplier[5:4] = 2'd1; tr[2] = 1'b1;
      lows = 0; dns = 0;
      for (int j = 1; j <= 30; j++) begin
         step();
         tr[2] = (j == 10);
         if (j == 11) chk("t3_restart", 64'(count[2*W +: W]), 64'd1);
         lows += (cf[2] == 1'b0);
         dns  += done[2];
      end
      chk("t3_lows", 64'(lows), 64'd24);
      chk("t3_dones", 64'(dns), 64'd1);

      // 4: all channels together, multipliers 0..3
      idle_all();
      mode = '0; multiplier = 8'b11_10_01_00; tr = '1;
      for (int c = 0; c < CH; c++) dstep[c] = 0;
      for (int j = 1; j <= 60; j++) begin
         step();
         tr = '0;
         for (int c = 0; c < CH; c++) if (done[c]) dstep[c] = j;
      end
      for (int c = 0; c < CH; c++) chk("t4_done_step", 64'(dstep[c]), 64'((7 << c) + 1));

      // 5: held trigger gives 7 low / 1 high; mid-count multiplier change is ignored
      multiplier = '0; tr[0] = 1'b1; highs = 0;
      for (int j = 1; j <= 24; j++) begin
         step();
         highs += cf[0];
      end
      chk("t5_highs", 64'(highs), 64'd3);
      tr[0] = 1'b0;
      idle_all();
      tr[0] = 1'b1; dstep[0] = 0;
      for (int j = 1; j <= 10; j++) begin
         step();
         tr[0] = 1'b0;
         if (j == 3) multiplier[1:0] = 2'd3;
         if (done[0]) dstep[0] = j;
      end
      chk("t5_mult_ignored", 64'(dstep[0]), 64'd8);

      // 6: tr with abort stays idle; async reset mid-count
      multiplier = '0; tr = 4'b0001; abort = 4'b0001;
      step();
      chk("t6_tr_abort", 64'(cf[0]), 64'h1);
      abort = '0;
      step();
      tr = '0;
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      chk("t6_async_cf", 64'(cf), 64'hF);
      chk("t6_async_done", 64'(done), 64'h0);
      chk("t6_async_count", 64'(count), 64'h0);
      step();
      reset = 1'b0;

      // random traffic against the model
      for (int j = 0; j < 3000; j++) begin
         for (int c = 0; c < CH; c++) begin
            tr[c]    = ($urandom_range(0, 15) == 0);
            abort[c] = ($urandom_range(0, 79) == 0);
         end
         multiplier = 8'($urandom);
         mode       = 8'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
